sie_event_tracker: RTL
======================

SIE_EVENT_TRACKER -- requirements
Module: sie_event_tracker

Interface
REQ-001 Parameters SHALL be: WIDTH, 18, sample width; FRAC, 14, fractional bits (Q14); NUM_HARMONICS, 5, harmonic count; ONSET_SAMPLES, 8, debounce length; REFRACTORY_SAMPLES, 400, lockout length (100 ms at 4 kHz); CNT_WIDTH, 16, counter width.
REQ-002 clk  input  1  system clock; one clock domain, all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-004 clk_en  input  1  4 kHz sample strobe; state advances only when high.
REQ-005 sie_per_harmonic  input  NUM_HARMONICS  per-harmonic SIE flag from the harmonic bank.
REQ-006 gain_per_harmonic_packed  input  NUM_HARMONICS*WIDTH  per-harmonic Q14 gain, harmonic h at [h*WIDTH +: WIDTH].
REQ-007 event_active  output  NUM_HARMONICS  harmonic h in ACTIVE.
REQ-008 event_start / event_end  output  NUM_HARMONICS each  one-clk pulses on ACTIVE entry / exit.
REQ-009 event_count_packed  output  NUM_HARMONICS*CNT_WIDTH  saturating event counters.
REQ-010 last_duration_packed  output  NUM_HARMONICS*CNT_WIDTH  length in samples of last completed event.
REQ-011 last_peak_packed  output  NUM_HARMONICS*WIDTH  peak gain of last completed event.
REQ-012 any_active  output  1  OR of event_active.
REQ-013 dominant_idx  output  3  harmonic with largest running peak among ACTIVE; 3'd7 if none.

Function
REQ-014 Per-harmonic FSM states SHALL be IDLE, ONSET, ACTIVE, REFRACTORY; all transitions only on clk_en=1.
REQ-015 IDLE: sie=1 -> ONSET, run counter=1; else stay.
REQ-016 ONSET: sie=0 -> IDLE, no outputs; sie=1 -> counter+1; counter reaching ONSET_SAMPLES -> ACTIVE.
REQ-017 ACTIVE entry: event_start[h]=1 that clk only; event_count+1 saturating at 2^CNT_WIDTH-1; running peak=current gain; running duration=ONSET_SAMPLES.
REQ-018 ACTIVE with sie=1: duration+1 saturating; running peak=max(peak, gain); negative gain treated as 0.
REQ-019 ACTIVE with sie=0: -> REFRACTORY; event_end[h]=1 that clk only; last_duration and last_peak latch running values (sample with sie=0 not counted).
REQ-020 REFRACTORY: sie ignored; lockout counter counts REFRACTORY_SAMPLES strobes, then -> IDLE; a sie=1 on the IDLE-entry strobe is not seen until the next strobe.
REQ-021 ONSET_SAMPLES=1 SHALL go IDLE -> ACTIVE over two strobes (ONSET still visited once).
REQ-022 clk_en=0: all state, counters, outputs held; pulses deasserted.
REQ-023 event_active = registered (state==ACTIVE); latency from qualifying strobe to event_active/event_start = 1 clk.
REQ-024 dominant_idx registered, updated every clk from current ACTIVE states and running peaks; ties -> lowest index; 1 clk behind event_active.
REQ-025 Simultaneous start on several harmonics: each pulses independently in the same clk.
REQ-026 Gain comparisons signed WIDTH-bit; no truncation of packed fields.

Reset
REQ-027 rst=0 SHALL asynchronously force every FSM to IDLE and all counters, pulses, event_active, any_active, last_*, event_count to 0, dominant_idx to 3'd7, including mid-event; release synchronous to clk.

Structure
REQ-028 Shared package: state encoding (2-bit), DOMINANT_NONE=3'd7, default ONSET/REFRACTORY constants, Q14 ONE.
REQ-029 One sub-module sie_event_fsm (single-harmonic FSM, counters, peak/duration latch), instantiated NUM_HARMONICS times by generate; top holds dominant arbiter and packing.

Verification
REQ-030 Harmonic 0 sie=1 for 8 strobes, gain 0x2000 -> event_start[0] on 8th strobe, event_count[0]=1, dominant_idx=0 one clk later.
REQ-031 sie=1 for 7 strobes then 0 -> no event_start, state IDLE, count 0.
REQ-032 Event of 20 strobes, gain ramp to 0x3800 then 0x1000 -> event_end, last_duration=20, last_peak=0x3800, 400-strobe lockout ignoring sie=1.
REQ-033 Harmonics 1 and 3 start same strobe, peaks 0x3000/0x3000 -> both pulses same clk, dominant_idx=1.
REQ-034 rst=0 mid-ACTIVE with clk_en=0 -> outputs 0 immediately, dominant_idx=7, no event_end.
REQ-035 Force count to 0xFFFF -> next event leaves 0xFFFF.

Source files
------------

// File: rtl/sie_event_tracker_pkg.sv
// sie_event_tracker_pkg: shared state encoding and constants for the SIE event tracker.
package sie_event_tracker_pkg;
   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_ONSET      = 2'd1,
      ST_ACTIVE     = 2'd2,
      ST_REFRACTORY = 2'd3
   } state_t;
   localparam logic [2:0]  DOMINANT_NONE              = 3'd7;
   localparam int          DEFAULT_ONSET_SAMPLES      = 8;
   localparam int          DEFAULT_REFRACTORY_SAMPLES = 400;
   localparam logic [17:0] Q14_ONE                    = 18'h04000;
endpackage

// File: rtl/sie_event_fsm.sv
// sie_event_fsm: single-harmonic onset/active/refractory tracker with event statistics.
module sie_event_fsm
   import sie_event_tracker_pkg::*;
#(
   parameter int WIDTH              = 18,
   parameter int ONSET_SAMPLES      = DEFAULT_ONSET_SAMPLES,
   parameter int REFRACTORY_SAMPLES = DEFAULT_REFRACTORY_SAMPLES,
   parameter int CNT_WIDTH          = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clk_en,
   input  logic                 sie,
   input  logic [WIDTH-1:0]     gain,
   output logic                 event_active,
   output logic                 event_start,
   output logic                 event_end,
   output logic [CNT_WIDTH-1:0] event_count,
   output logic [CNT_WIDTH-1:0] last_duration,
   output logic [WIDTH-1:0]     last_peak,
   output logic [WIDTH-1:0]     run_peak
);
   // One timer serves both the onset debounce and the refractory lockout.
   localparam int TMAX = ONSET_SAMPLES > REFRACTORY_SAMPLES ? ONSET_SAMPLES : REFRACTORY_SAMPLES;
   localparam int TW   = $clog2(TMAX + 2);

   state_t               state, state_n;
   logic [TW-1:0]        timer, timer_n;
   logic [CNT_WIDTH-1:0] dur, dur_n, count_n, ldur_n;
   logic [WIDTH-1:0]     peak_n, lpeak_n, gain_pos;
   logic                 start_n, end_n;

   assign gain_pos     = gain[WIDTH-1] ? '0 : gain;
   assign event_active = (state == ST_ACTIVE);

   always_comb begin
      state_n = state;
      timer_n = timer;
      dur_n   = dur;
      peak_n  = run_peak;
      count_n = event_count;
      ldur_n  = last_duration;
      lpeak_n = last_peak;
      start_n = 1'b0;
      end_n   = 1'b0;
      if (clk_en) begin
         case (state)
            ST_IDLE: if (sie) begin
               state_n = ST_ONSET;
               timer_n = TW'(1);
            end
            ST_ONSET: if (!sie) begin
               state_n = ST_IDLE;
            end else if (int'(timer) + 1 >= ONSET_SAMPLES) begin
               state_n = ST_ACTIVE;
               start_n = 1'b1;
               count_n = &event_count ? event_count : event_count + 1'b1;
               dur_n   = CNT_WIDTH'(ONSET_SAMPLES);
               peak_n  = gain_pos;
            end else begin
               timer_n = timer + 1'b1;
            end
            ST_ACTIVE: if (sie) begin
               dur_n  = &dur ? dur : dur + 1'b1;
               peak_n = $signed(gain_pos) > $signed(run_peak) ? gain_pos : run_peak;
            end else begin
               state_n = ST_REFRACTORY;
               end_n   = 1'b1;
               ldur_n  = dur;
               lpeak_n = run_peak;
               timer_n = '0;
            end
            default: if (int'(timer) + 1 >= REFRACTORY_SAMPLES) begin
               state_n = ST_IDLE;
               timer_n = '0;
            end else begin
               timer_n = timer + 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= ST_IDLE;
         timer         <= '0;
         dur           <= '0;
         run_peak      <= '0;
         event_count   <= '0;
         last_duration <= '0;
         last_peak     <= '0;
         event_start   <= 1'b0;
         event_end     <= 1'b0;
      end else begin
         state         <= state_n;
         timer         <= timer_n;
         dur           <= dur_n;
         run_peak      <= peak_n;
         event_count   <= count_n;
         last_duration <= ldur_n;
         last_peak     <= lpeak_n;
         event_start   <= start_n;
         event_end     <= end_n;
      end
   end
endmodule

// File: rtl/sie_event_tracker.sv
// sie_event_tracker: per-harmonic SIE event trackers plus dominant-harmonic arbiter.
module sie_event_tracker
   import sie_event_tracker_pkg::*;
#(
   parameter int WIDTH              = 18,
   parameter int FRAC               = 14,
   parameter int NUM_HARMONICS      = 5,
   parameter int ONSET_SAMPLES      = DEFAULT_ONSET_SAMPLES,
   parameter int REFRACTORY_SAMPLES = DEFAULT_REFRACTORY_SAMPLES,
   parameter int CNT_WIDTH          = 16
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               clk_en,
   input  logic [NUM_HARMONICS-1:0]           sie_per_harmonic,
   input  logic [NUM_HARMONICS*WIDTH-1:0]     gain_per_harmonic_packed,
   output logic [NUM_HARMONICS-1:0]           event_active,
   output logic [NUM_HARMONICS-1:0]           event_start,
   output logic [NUM_HARMONICS-1:0]           event_end,
   output logic [NUM_HARMONICS*CNT_WIDTH-1:0] event_count_packed,
   output logic [NUM_HARMONICS*CNT_WIDTH-1:0] last_duration_packed,
   output logic [NUM_HARMONICS*WIDTH-1:0]     last_peak_packed,
   output logic                               any_active,
   output logic [2:0]                         dominant_idx
);
   logic [WIDTH-1:0] peaks [NUM_HARMONICS];
   logic [WIDTH-1:0] best;
   logic [2:0]       dom_n;
   logic             found;

   for (genvar h = 0; h < NUM_HARMONICS; h++) begin : g_h
      sie_event_fsm #(
         .WIDTH(WIDTH),
         .ONSET_SAMPLES(ONSET_SAMPLES),
         .REFRACTORY_SAMPLES(REFRACTORY_SAMPLES),
         .CNT_WIDTH(CNT_WIDTH)
      ) u_fsm (
         .clk(clk),
         .rst(rst),
         .clk_en(clk_en),
         .sie(sie_per_harmonic[h]),
         .gain(gain_per_harmonic_packed[h*WIDTH +: WIDTH]),
         .event_active(event_active[h]),
         .event_start(event_start[h]),
         .event_end(event_end[h]),
         .event_count(event_count_packed[h*CNT_WIDTH +: CNT_WIDTH]),
         .last_duration(last_duration_packed[h*CNT_WIDTH +: CNT_WIDTH]),
         .last_peak(last_peak_packed[h*WIDTH +: WIDTH]),
         .run_peak(peaks[h])
      );
   end

   assign any_active = |event_active;

   // Strict greater-than keeps the lowest index on ties.
   always_comb begin
      dom_n = DOMINANT_NONE;
      best  = '0;
      found = 1'b0;
      for (int i = 0; i < NUM_HARMONICS; i++) begin
         if (event_active[i] && (!found || $signed(peaks[i]) > $signed(best))) begin
            dom_n = 3'(i);
            best  = peaks[i];
            found = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) dominant_idx <= DOMINANT_NONE;
      else      dominant_idx <= dom_n;
   end
endmodule
